// File: rtl/nios2vga_sysid_checker_pkg.sv
// Shared definitions for the nios2VGA system-ID checker: FSM state
// encoding and the word addresses of the sysid slave registers.
package nios2VGA_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ_ID,
    ST_WAIT_ID,
    ST_REQ_TS,
    ST_WAIT_TS,
    ST_FINISH
  } state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

endpackage

// File: rtl/nios2vga_sysid_checker.sv
// Avalon-MM read master that fetches the sysid ID word (address 0) and
// timestamp word (address 1) and compares them to build-time values.
// Optional feature: define SYSID_CHECK_TIMEOUT_EN to abort a check whose
// current read stalls for TIMEOUT_CYCLES cycles.
module nios2vga_sysid_checker
  import nios2VGA_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1389198328,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  // The timeout budget lives in an 8-bit counter.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be within 1..255");
  end

  state_t state;
  logic   id_capture;
  logic   ts_capture;
  logic   expire;

  // Data is taken either in the accept cycle (latency-0 slave) or while waiting.
  always_comb begin
    id_capture = avm_readdatavalid &&
                 ((state == ST_REQ_ID && !avm_waitrequest) || state == ST_WAIT_ID);
    ts_capture = avm_readdatavalid &&
                 ((state == ST_REQ_TS && !avm_waitrequest) || state == ST_WAIT_TS);
  end

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] cnt;
  logic       enter_req;
  logic       in_txn;

  // Counter restarts on every new request and runs while a read is pending.
  always_comb begin
    enter_req = (state == ST_IDLE && start) || id_capture;
    in_txn    = (state == ST_REQ_ID) || (state == ST_WAIT_ID) ||
                (state == ST_REQ_TS) || (state == ST_WAIT_TS);
    expire    = in_txn && (cnt >= TIMEOUT_LAST);
  end

  // Per-transaction cycle counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (enter_req) begin
      cnt <= '0;
    end else if (in_txn) begin
      cnt <= cnt + 8'd1;
    end
  end
`else
  // Without the timeout feature the checker waits indefinitely.
  always_comb expire = 1'b0;
`endif

  // Check sequencer with registered bus strobes and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      avm_address <= SYSID_ADDR_ID;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_REQ_ID;
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_ID;
            busy        <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
          end
        end
        ST_REQ_ID, ST_WAIT_ID: begin
          if (id_capture) begin
            id_value    <= avm_readdata;
            id_ok       <= (avm_readdata == EXPECTED_ID);
            avm_read    <= 1'b1;
            avm_address <= SYSID_ADDR_TS;
            state       <= ST_REQ_TS;
          end else if (state == ST_REQ_ID && !avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_WAIT_ID;
          end else if (expire) begin
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_REQ_TS, ST_WAIT_TS: begin
          if (ts_capture) begin
            ts_value <= avm_readdata;
            ts_ok    <= (avm_readdata == EXPECTED_TIMESTAMP);
            avm_read <= 1'b0;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end else if (state == ST_REQ_TS && !avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_WAIT_TS;
          end else if (expire) begin
            avm_read <= 1'b0;
            timeout  <= 1'b1;
            done     <= 1'b1;
            state    <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios2vga_sysid_checker.sv
// Scoreboard bench for nios2vga_sysid_checker: stimulus pushes expected
// read strobes and check results; negedge monitors pop and compare.
module tb_nios2vga_sysid_checker;

  localparam logic [31:0] GOOD_ID = 32'd0;
  localparam logic [31:0] GOOD_TS = 32'd1389198328;
`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam int unsigned TO_CYC = 10;
`else
  localparam int unsigned TO_CYC = 255;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  nios2vga_sysid_checker #(
    .EXPECTED_ID(GOOD_ID),
    .EXPECTED_TIMESTAMP(GOOD_TS),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata),
    .busy(busy),
    .done(done),
    .id_ok(id_ok),
    .ts_ok(ts_ok),
    .timeout(timeout),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  typedef struct {
    int unsigned rel;
    logic        addr;
  } rd_t;

  typedef struct {
    int unsigned rel;
    logic        id_ok;
    logic        ts_ok;
    logic        to;
    logic [31:0] idv;
    logic [31:0] tsv;
  } res_t;

  rd_t  rdq[$];
  res_t resq[$];

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;
  int unsigned base = 0;

  // Slave model configuration.
  logic [31:0] mem_id = GOOD_ID;
  logic [31:0] mem_ts = GOOD_TS;
  int unsigned wait_cycles = 0;
  bit          lat0 = 0;
  bit          stuck = 0;
  bit          pend = 0;
  logic [31:0] pend_data = '0;
  int unsigned wcnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Avalon slave: waitrequest count, latency 0 or 1, optional permanent stall.
  always @(negedge clock) begin
    logic [31:0] d;
    if (!reset_n) begin
      pend = 0;
      wcnt = 0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
    end else begin
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      if (pend) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = pend_data;
        pend = 0;
      end
      if (avm_read) begin
        if (stuck || wcnt < wait_cycles) begin
          avm_waitrequest = 1'b1;
          wcnt++;
        end else begin
          wcnt = 0;
          d = avm_address ? mem_ts : mem_id;
          if (lat0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = d;
          end else begin
            pend = 1;
            pend_data = d;
          end
        end
      end
    end
  end

  // Monitor: every asserted read strobe and every done pulse is matched.
  always @(negedge clock) begin
    if (reset_n) begin
      if (avm_read) begin
        if (rdq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_read: got addr %0d at rel cycle %0d expected none", avm_address, cyc - base);
        end else begin
          rd_t e;
          e = rdq.pop_front();
          chk("read_cycle", cyc - base, e.rel);
          chk("read_addr", {31'd0, avm_address}, {31'd0, e.addr});
        end
      end
      if (done) begin
        if (resq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_done: got done at rel cycle %0d expected none", cyc - base);
        end else begin
          res_t r;
          r = resq.pop_front();
          chk("done_cycle", cyc - base, r.rel);
          chk("id_ok", {31'd0, id_ok}, {31'd0, r.id_ok});
          chk("ts_ok", {31'd0, ts_ok}, {31'd0, r.ts_ok});
          chk("timeout", {31'd0, timeout}, {31'd0, r.to});
          chk("id_value", id_value, r.idv);
          chk("ts_value", ts_value, r.tsv);
          chk("busy_at_done", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic push_rd(input int unsigned rel, input logic addr);
    rd_t e;
    e.rel = rel;
    e.addr = addr;
    rdq.push_back(e);
  endtask

  task automatic push_res(input int unsigned rel, input logic i_ok, input logic t_ok,
                          input logic to, input logic [31:0] idv, input logic [31:0] tsv);
    res_t r;
    r.rel = rel; r.id_ok = i_ok; r.ts_ok = t_ok; r.to = to; r.idv = idv; r.tsv = tsv;
    resq.push_back(r);
  endtask

  // Start pulse in cycle 0; returns at the negedge of cycle 1.
  task automatic issue_start();
    @(negedge clock);
    start = 1'b1;
    base = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((rdq.size() != 0 || resq.size() != 0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      n_total++;
      $display("FAIL drain_timeout: got %0d reads %0d results pending expected 0", rdq.size(), resq.size());
      rdq.delete();
      resq.delete();
    end
    repeat (3) @(negedge clock);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_read"}, {31'd0, avm_read}, 32'd0);
    chk({tag, "_addr"}, {31'd0, avm_address}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_id_ok"}, {31'd0, id_ok}, 32'd0);
    chk({tag, "_ts_ok"}, {31'd0, ts_ok}, 32'd0);
    chk({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    chk({tag, "_id_value"}, id_value, 32'd0);
    chk({tag, "_ts_value"}, ts_value, 32'd0);
  endtask

  initial begin
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Zero-wait latency-1 slave, good identity.
    push_rd(1, 1'b0); push_rd(3, 1'b1);
    push_res(5, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
    issue_start();
    drain();

    // Wrong timestamp; extra start while busy must be ignored.
    mem_ts = 32'd1389198327;
    push_rd(1, 1'b0); push_rd(3, 1'b1);
    push_res(5, 1'b1, 1'b0, 1'b0, GOOD_ID, 32'd1389198327);
    issue_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    drain();
    chk("hold_ts_value", ts_value, 32'd1389198327);
    chk("hold_id_ok", {31'd0, id_ok}, 32'd1);

    // Three waitrequest cycles per read; results cleared by start.
    mem_ts = GOOD_TS;
    wait_cycles = 3;
    for (int unsigned k = 1; k <= 4; k++) push_rd(k, 1'b0);
    for (int unsigned k = 6; k <= 9; k++) push_rd(k, 1'b1);
    push_res(11, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
    issue_start();
    chk("clear_ts_value", ts_value, 32'd0);
    chk("clear_ts_ok", {31'd0, ts_ok}, 32'd0);
    chk("clear_id_ok", {31'd0, id_ok}, 32'd0);
    chk("busy_running", {31'd0, busy}, 32'd1);
    drain();
    wait_cycles = 0;

    // Latency-0 slave: wait states skipped.
    lat0 = 1;
    push_rd(1, 1'b0); push_rd(2, 1'b1);
    push_res(3, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
    issue_start();
    drain();
    lat0 = 0;

    // Wrong ID word.
    mem_id = 32'hDEADBEEF;
    push_rd(1, 1'b0); push_rd(3, 1'b1);
    push_res(5, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, GOOD_TS);
    issue_start();
    drain();
    mem_id = GOOD_ID;

`ifdef SYSID_CHECK_TIMEOUT_EN
    // Stalled slave: read abandoned after TIMEOUT_CYCLES.
    stuck = 1;
    for (int unsigned k = 1; k <= 10; k++) push_rd(k, 1'b0);
    push_res(11, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
    issue_start();
    drain();
    chk("timeout_hold", {31'd0, timeout}, 32'd1);
    stuck = 0;
`endif

    // Reset in the middle of a stalled check.
    stuck = 1;
    push_rd(1, 1'b0); push_rd(2, 1'b0); push_rd(3, 1'b0);
    issue_start();
    @(negedge clock);
    @(negedge clock);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1 check_reset_outputs("midreset");
    stuck = 0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    chk("midreset_queue", rdq.size(), 32'd0);
    repeat (2) @(negedge clock);

    // Recovery after reset.
    push_rd(1, 1'b0); push_rd(3, 1'b1);
    push_res(5, 1'b1, 1'b1, 1'b0, GOOD_ID, GOOD_TS);
    issue_start();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
